// File: rtl/krz_gpio_irq.sv
// GPIO edge-detect interrupt stage: per-bit rise/fall enables set sticky pending
// bits, irq is their OR, and a Wishbone classic slave exposes the registers.
module krz_gpio_irq #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] gpio_read,
    input  logic         wb_cyc_i,
    input  logic         wb_stb_i,
    input  logic         wb_we_i,
    input  logic [1:0]   wb_adr_i,
    input  logic [31:0]  wb_dat_i,
    output logic [31:0]  wb_dat_o,
    output logic         wb_ack_o,
    output logic         irq
);

    localparam logic [1:0] ADR_IN      = 2'd0;
    localparam logic [1:0] ADR_RISE_EN = 2'd1;
    localparam logic [1:0] ADR_FALL_EN = 2'd2;
    localparam logic [1:0] ADR_PENDING = 2'd3;

    logic [N-1:0] prev;
    logic [N-1:0] rise_en;
    logic [N-1:0] fall_en;
    logic [N-1:0] pending;
    logic         primed;

    logic         access;
    logic         wr_acc;
    logic         rd_acc;
    logic [N-1:0] wr_bits;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] w1c;
    logic [N-1:0] pending_nxt;
    logic [31:0]  rd_data;
    logic         unused_dat;

    // Handshake: a request (cyc & stb) is accepted on any edge where ack is low;
    // ack follows for exactly one cycle, so a held strobe transfers every 2 cycles.
    assign access  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wr_acc  = access & wb_we_i;
    assign rd_acc  = access & ~wb_we_i;
    assign wr_bits = wb_dat_i[N-1:0];

    // Edges are masked until one clock has captured a real previous level.
    assign rise = primed ? (gpio_read & ~prev) : '0;
    assign fall = primed ? (~gpio_read & prev) : '0;

    assign w1c = (wr_acc && wb_adr_i == ADR_PENDING) ? wr_bits : '0;

    // Set terms are ORed after the clear, so a new edge beats a same-cycle W1C.
    assign pending_nxt = (pending & ~w1c) | (rise & rise_en) | (fall & fall_en);

    assign irq = |pending;

    always_comb begin
        rd_data = '0;
        case (wb_adr_i)
            ADR_IN:      rd_data = 32'(gpio_read);
            ADR_RISE_EN: rd_data = 32'(rise_en);
            ADR_FALL_EN: rd_data = 32'(fall_en);
            ADR_PENDING: rd_data = 32'(pending);
            default:     rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev     <= '0;
            primed   <= 1'b0;
            pending  <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            prev     <= gpio_read;
            primed   <= 1'b1;
            pending  <= pending_nxt;
            wb_ack_o <= access;
            wb_dat_o <= rd_acc ? rd_data : '0;
            if (wr_acc && wb_adr_i == ADR_RISE_EN) begin
                rise_en <= wr_bits;
            end
            if (wr_acc && wb_adr_i == ADR_FALL_EN) begin
                fall_en <= wr_bits;
            end
        end
    end

    // Upper write-data bits have no register behind them when N < 32.
    assign unused_dat = ^wb_dat_i;

endmodule

// File: tb/tb_krz_gpio_irq.sv
// Bench for krz_gpio_irq: directed scenarios plus random traffic, scored each
// cycle against a bit-level behavioural model with an expected-response queue.
module tb_krz_gpio_irq;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  gpio_read = 16'hFFFF;
    logic          wb_cyc_i = 1'b0;
    logic          wb_stb_i = 1'b0;
    logic          wb_we_i = 1'b0;
    logic [1:0]    wb_adr_i = 2'd0;
    logic [31:0]   wb_dat_i = '0;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          irq;

    int n_checks = 0;
    int n_pass = 0;

    krz_gpio_irq #(.N(N)) dut (
        .clk(clk), .rst(rst), .gpio_read(gpio_read),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .irq(irq)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0]  m_pending = '0;
    logic [N-1:0]  m_rise_en = '0;
    logic [N-1:0]  m_fall_en = '0;
    logic [N-1:0]  m_last_level = '0;
    int            m_clocks_since_reset = 0;
    logic          m_ack = 1'b0;
    logic [31:0]   exp_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pending = '0; m_rise_en = '0; m_fall_en = '0;
            m_last_level = '0; m_clocks_since_reset = 0; m_ack = 1'b0;
            exp_q.delete();
        end else begin
            logic        taken;
            logic [N-1:0] cleared;
            logic [N-1:0] new_pending;
            taken   = wb_cyc_i && wb_stb_i && !m_ack;
            cleared = '0;
            if (taken) begin
                if (wb_we_i) exp_q.push_back(32'd0);
                else case (wb_adr_i)
                    2'd0: exp_q.push_back({16'd0, gpio_read});
                    2'd1: exp_q.push_back({16'd0, m_rise_en});
                    2'd2: exp_q.push_back({16'd0, m_fall_en});
                    default: exp_q.push_back({16'd0, m_pending});
                endcase
                if (wb_we_i && wb_adr_i == 2'd3) cleared = wb_dat_i[N-1:0];
            end
            for (int i = 0; i < N; i++) begin
                bit went_up, went_down;
                went_up   = m_clocks_since_reset > 0 && m_last_level[i] == 1'b0 && gpio_read[i] == 1'b1;
                went_down = m_clocks_since_reset > 0 && m_last_level[i] == 1'b1 && gpio_read[i] == 1'b0;
                if ((went_up && m_rise_en[i]) || (went_down && m_fall_en[i])) new_pending[i] = 1'b1;
                else if (cleared[i]) new_pending[i] = 1'b0;
                else new_pending[i] = m_pending[i];
            end
            m_pending = new_pending;
            if (taken && wb_we_i && wb_adr_i == 2'd1) m_rise_en = wb_dat_i[N-1:0];
            if (taken && wb_we_i && wb_adr_i == 2'd2) m_fall_en = wb_dat_i[N-1:0];
            m_ack = taken;
            m_last_level = gpio_read;
            m_clocks_since_reset++;
        end
    end

    // ---------------- scoreboard: every cycle on the falling edge ----------------
    always @(negedge clk) begin
        check("ack", {31'd0, wb_ack_o}, {31'd0, m_ack});
        check("irq", {31'd0, irq}, {31'd0, |m_pending});
        if (wb_ack_o) begin
            check("ack_has_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) check("rdata", wb_dat_o, exp_q.pop_front());
        end else begin
            check("dat_idle", wb_dat_o, 32'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wb_xfer(input logic we, input logic [1:0] adr, input logic [31:0] dat,
                           output logic [31:0] rd, output logic irq_at_ack);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        tick();
        check("xfer_ack", {31'd0, wb_ack_o}, 32'd1);
        rd = wb_dat_o;
        irq_at_ack = irq;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = '0;
        tick();
    endtask

    task automatic wb_write(input logic [1:0] adr, input logic [31:0] dat);
        logic [31:0] rd;
        logic        ia;
        wb_xfer(1'b1, adr, dat, rd, ia);
    endtask

    task automatic wb_read_check(input string name, input logic [1:0] adr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        ia;
        wb_xfer(1'b0, adr, 32'd0, rd, ia);
        check(name, rd, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rd;
        logic        ia;
        int          acks;

        // 1: reset with all inputs high, no spurious edges afterwards
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("post_reset_irq", {31'd0, irq}, 32'd0);
            tick();
        end
        wb_read_check("post_reset_pending", 2'd3, 32'd0);

        // 2: rising edge on bit 0, read and clear
        gpio_read = 16'h0000;
        tick();
        wb_write(2'd1, 32'h0000_0001);
        gpio_read[0] = 1'b1;
        tick();
        check("rise0_irq", {31'd0, irq}, 32'd1);
        wb_read_check("rise0_pending", 2'd3, 32'h0000_0001);
        wb_xfer(1'b1, 2'd3, 32'h0000_0001, rd, ia);
        check("w1c_irq_clear", {31'd0, irq}, 32'd0);

        // 3: falling edge on bit 15 collides with a W1C of bit 15
        wb_write(2'd2, 32'h0000_8000);
        gpio_read[15] = 1'b1; tick();
        gpio_read[15] = 1'b0; tick();
        wb_read_check("fall15_pending", 2'd3, 32'h0000_8000);
        gpio_read[15] = 1'b1; tick();
        gpio_read[15] = 1'b0;
        wb_write(2'd3, 32'h0000_8000);
        wb_read_check("set_wins", 2'd3, 32'h0000_8000);
        wb_write(2'd3, 32'h0000_8000);
        wb_read_check("fall15_cleared", 2'd3, 32'h0000_0000);

        // 4: edges on a disabled bit are dropped; enabling later does not set
        wb_write(2'd1, 32'h0000_0000);
        gpio_read[3] = 1'b1; tick();
        gpio_read[3] = 1'b0; tick();
        wb_write(2'd1, 32'h0000_0008);
        wb_read_check("late_enable", 2'd3, 32'h0000_0000);
        gpio_read[3] = 1'b1; tick();
        wb_read_check("rise3_pending", 2'd3, 32'h0000_0008);
        wb_write(2'd3, 32'h0000_0008);
        wb_write(2'd1, 32'h0000_0000);
        wb_write(2'd2, 32'h0000_0000);

        // 5: read IN, then hold strobe to see ack every other cycle
        gpio_read = 16'hA5A5; tick();
        wb_read_check("read_in", 2'd0, 32'h0000_A5A5);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 2'd0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("held_stb_ack", {31'd0, wb_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
            acks += int'(wb_ack_o);
        end
        check("held_stb_ack_count", acks, 32'd3);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();

        // 6: async reset with pending bits and an ack in flight
        wb_write(2'd1, 32'h0000_00F0);
        gpio_read[7:4] = 4'h0; tick();
        gpio_read[7:4] = 4'hF; tick();
        wb_read_check("pending_f0", 2'd3, 32'h0000_00F0);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 2'd3;
        tick();
        rst = 1'b1;
        #1;
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        wb_read_check("after_rst_pending", 2'd3, 32'd0);
        wb_read_check("after_rst_rise_en", 2'd1, 32'd0);

        // random traffic scored by the model
        for (int c = 0; c < 3000; c++) begin
            gpio_read = gpio_read ^ N'($urandom & $urandom & $urandom);
            wb_cyc_i  = ($urandom_range(0, 9) < 7);
            wb_stb_i  = ($urandom_range(0, 9) < 7);
            wb_we_i   = $urandom_range(0, 1) == 1;
            wb_adr_i  = 2'($urandom_range(0, 3));
            wb_dat_i  = $urandom;
            tick();
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        repeat (3) tick();
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
